// File: rtl/exe_mem_reg_pkg.sv
// Shared constants and types for the EXE->MEM->WB register slice.
// Holds opcode defaults, writeback-select encodings and bus FSM states.
package exe_mem_reg_pkg;

    localparam logic [5:0]  DEF_OP_LW       = 6'b100011;
    localparam logic [5:0]  DEF_OP_SW       = 6'b101011;
    localparam logic [31:0] DEF_LINK_OFFSET = 32'd8;
    localparam logic [31:0] WORD_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_ALU2 = 2'b11
    } wsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } dmem_state_e;

endpackage

// File: rtl/exe_mem_reg_dmem_bus_fsm.sv
// Data-memory bus FSM: request registers, load buffer, stall generation.
// Ports: clk/reset, ena, EXE opcode/addr/wdata in; dmem req/resp bus; stall and load_buf out.
module dmem_bus_fsm
    import exe_mem_reg_pkg::*;
#(
    parameter logic [5:0] OP_LW = DEF_OP_LW,
    parameter logic [5:0] OP_SW = DEF_OP_SW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_valid,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic        stall,
    output logic [31:0] load_buf
);

    dmem_state_e r_state;
    logic        r_req_valid;
    logic        r_req_we;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [31:0] r_load_buf;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_memop;

    assign w_is_lw = (opcode == OP_LW);
    assign w_is_sw = (opcode == OP_SW);
    assign w_memop = w_is_lw | w_is_sw;

    // The op is already known in IDLE, so stall from that cycle on.
    assign stall = ((r_state == ST_IDLE) & w_memop)
                 | (r_state == ST_REQ)
                 | (r_state == ST_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_load_buf  <= 32'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_memop) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_req_we    <= w_is_sw;
                        r_req_addr  <= addr & WORD_MASK;
                        r_req_wdata <= wdata;
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_req_we ? ST_DONE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_valid) begin
                        r_load_buf <= resp_rdata;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ena) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_valid = r_req_valid;
    assign req_we    = r_req_we;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign load_buf  = r_load_buf;

endmodule

// File: rtl/exe_mem_reg.sv
// EXE/MEM/WB slice: runs lw/sw on the dmem bus, stalls, registers WB values.
// Ports: clk/reset/ena, exe_* EXE results, dmem_* bus, mem_stall_req, wb_* toward WB.
module exe_mem_reg
    import exe_mem_reg_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = DEF_LINK_OFFSET,
    parameter logic [5:0]  OP_LW       = DEF_OP_LW,
    parameter logic [5:0]  OP_SW       = DEF_OP_SW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [5:0]  exe_opcode_in,
    input  logic [31:0] exe_mem_fetch_addr,
    input  logic [31:0] exe_GPR_rt_in,
    input  logic [31:0] exe_alu_result_in,
    input  logic [31:0] exe_pc_in,
    input  logic        exe_GPR_we_in,
    input  logic [4:0]  exe_GPR_waddr_in,
    input  logic [1:0]  exe_GPR_wdata_select_in,
    output logic        dmem_req_valid,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_req_ready,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_rdata,
    output logic        mem_stall_req,
    output logic        wb_GPR_we,
    output logic [4:0]  wb_GPR_waddr,
    output logic [31:0] wb_GPR_wdata,
    output logic [31:0] wb_pc_out
);

    logic        w_stall;
    logic [31:0] w_load_buf;
    logic [31:0] w_wb_wdata;
    logic        w_capture;
    logic        r_wb_we;
    logic [4:0]  r_wb_waddr;
    logic [31:0] r_wb_wdata;
    logic [31:0] r_wb_pc;

    dmem_bus_fsm #(
        .OP_LW (OP_LW),
        .OP_SW (OP_SW)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .opcode     (exe_opcode_in),
        .addr       (exe_mem_fetch_addr),
        .wdata      (exe_GPR_rt_in),
        .req_valid  (dmem_req_valid),
        .req_we     (dmem_req_we),
        .req_addr   (dmem_req_addr),
        .req_wdata  (dmem_req_wdata),
        .req_ready  (dmem_req_ready),
        .resp_valid (dmem_resp_valid),
        .resp_rdata (dmem_resp_rdata),
        .stall      (w_stall),
        .load_buf   (w_load_buf)
    );

    assign mem_stall_req = w_stall;
    assign w_capture     = ena & ~w_stall;

    always_comb begin
        w_wb_wdata = exe_alu_result_in;
        unique case (exe_GPR_wdata_select_in)
            SEL_LOAD: w_wb_wdata = w_load_buf;
            SEL_LINK: w_wb_wdata = exe_pc_in + LINK_OFFSET;
            default:  w_wb_wdata = exe_alu_result_in;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_we    <= 1'b0;
            r_wb_waddr <= 5'd0;
            r_wb_wdata <= 32'd0;
            r_wb_pc    <= 32'd0;
        end else if (w_capture) begin
            r_wb_we    <= exe_GPR_we_in;
            r_wb_waddr <= exe_GPR_waddr_in;
            r_wb_wdata <= w_wb_wdata;
            r_wb_pc    <= exe_pc_in;
        end
    end

    assign wb_GPR_we    = r_wb_we;
    assign wb_GPR_waddr = r_wb_waddr;
    assign wb_GPR_wdata = r_wb_wdata;
    assign wb_pc_out    = r_wb_pc;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: directed ops, bus responder, monitors.
// Expected WB values and bus requests are queued at issue, checked by monitors.
module tb_exe_mem_reg;
    import exe_mem_reg_pkg::*;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    localparam logic [5:0] OP_ADDU = 6'b000000;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena_gate;
    logic        ena;
    logic [5:0]  exe_opcode_in;
    logic [31:0] exe_mem_fetch_addr;
    logic [31:0] exe_GPR_rt_in;
    logic [31:0] exe_alu_result_in;
    logic [31:0] exe_pc_in;
    logic        exe_GPR_we_in;
    logic [4:0]  exe_GPR_waddr_in;
    logic [1:0]  exe_GPR_wdata_select_in;
    logic        dmem_req_valid;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        mem_stall_req;
    logic        wb_GPR_we;
    logic [4:0]  wb_GPR_waddr;
    logic [31:0] wb_GPR_wdata;
    logic [31:0] wb_pc_out;

    wb_t wb_q[$];
    rq_t rq_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    assign ena = ena_gate & ~mem_stall_req;

    exe_mem_reg dut (
        .clk                     (clk),
        .reset                   (reset),
        .ena                     (ena),
        .exe_opcode_in           (exe_opcode_in),
        .exe_mem_fetch_addr      (exe_mem_fetch_addr),
        .exe_GPR_rt_in           (exe_GPR_rt_in),
        .exe_alu_result_in       (exe_alu_result_in),
        .exe_pc_in               (exe_pc_in),
        .exe_GPR_we_in           (exe_GPR_we_in),
        .exe_GPR_waddr_in        (exe_GPR_waddr_in),
        .exe_GPR_wdata_select_in (exe_GPR_wdata_select_in),
        .dmem_req_valid          (dmem_req_valid),
        .dmem_req_we             (dmem_req_we),
        .dmem_req_addr           (dmem_req_addr),
        .dmem_req_wdata          (dmem_req_wdata),
        .dmem_req_ready          (dmem_req_ready),
        .dmem_resp_valid         (dmem_resp_valid),
        .dmem_resp_rdata         (dmem_resp_rdata),
        .mem_stall_req           (mem_stall_req),
        .wb_GPR_we               (wb_GPR_we),
        .wb_GPR_waddr            (wb_GPR_waddr),
        .wb_GPR_wdata            (wb_GPR_wdata),
        .wb_pc_out               (wb_pc_out)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // WB monitor: a capture edge is one where ena is high and no stall.
    initial begin : wb_mon
        wb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b1 && ena === 1'b1 && mem_stall_req === 1'b0) begin
                @(posedge clk);
                #2;
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected_capture", 32'd1, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_we", {31'd0, wb_GPR_we}, {31'd0, e.we});
                    chk("wb_waddr", {27'd0, wb_GPR_waddr}, {27'd0, e.waddr});
                    chk("wb_wdata", wb_GPR_wdata, e.wdata);
                    chk("wb_pc", wb_pc_out, e.pc);
                end
            end
        end
    end

    // Bus monitor: one pop per accepted request.
    initial begin : bus_mon
        rq_t r;
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b1 && dmem_req_valid === 1'b1 && dmem_req_ready === 1'b1) begin
                if (rq_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rq_q.pop_front();
                    chk("req_we", {31'd0, dmem_req_we}, {31'd0, r.we});
                    chk("req_addr", dmem_req_addr, r.addr);
                    chk("req_wdata", dmem_req_wdata, r.wdata);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic run_op(
        input string       nm,
        input logic [5:0]  op,
        input logic [31:0] addr,
        input logic [31:0] rt,
        input logic [31:0] alu,
        input logic [31:0] pc,
        input logic        we,
        input logic [4:0]  waddr,
        input logic [1:0]  sel,
        input int          rdy_wait,
        input int          rsp_wait,
        input logic [31:0] rdata,
        input bit          spur,
        input int          exp_stall,
        input logic [31:0] exp_wdata,
        input logic [31:0] exp_raddr
    );
        int  stalls;
        int  cyc;
        int  rw;
        int  rl;
        bit  done;
        bit  first;
        bit  unstable;
        bit  memop;
        rq_t seen;
        rq_t r;
        wb_t e;
        stalls   = 0;
        cyc      = 0;
        rw       = rdy_wait;
        rl       = -1;
        done     = 1'b0;
        first    = 1'b1;
        unstable = 1'b0;
        memop    = (op == DEF_OP_LW) || (op == DEF_OP_SW);
        exe_opcode_in           = op;
        exe_mem_fetch_addr      = addr;
        exe_GPR_rt_in           = rt;
        exe_alu_result_in       = alu;
        exe_pc_in               = pc;
        exe_GPR_we_in           = we;
        exe_GPR_waddr_in        = waddr;
        exe_GPR_wdata_select_in = sel;
        ena_gate                = 1'b1;
        e.we    = we;
        e.waddr = waddr;
        e.wdata = exp_wdata;
        e.pc    = pc;
        wb_q.push_back(e);
        if (memop) begin
            r.we    = (op == DEF_OP_SW);
            r.addr  = exp_raddr;
            r.wdata = rt;
            rq_q.push_back(r);
        end
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (mem_stall_req) stalls++;
            else done = 1'b1;
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = 32'd0;
            if (cyc == 1 && spur) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = 32'hBAD0_BAD0;
            end
            if (rl == 1) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = rdata;
            end
            if (rl > 0) rl--;
            dmem_req_ready = 1'b0;
            if (dmem_req_valid) begin
                if (first) begin
                    seen  = {dmem_req_we, dmem_req_addr, dmem_req_wdata};
                    first = 1'b0;
                end else if (seen !== {dmem_req_we, dmem_req_addr, dmem_req_wdata}) begin
                    unstable = 1'b1;
                end
                if (rw > 0) begin
                    rw--;
                end else begin
                    dmem_req_ready = 1'b1;
                    if (!dmem_req_we) rl = rsp_wait;
                end
            end else if (cyc == 1 && spur) begin
                dmem_req_ready = 1'b1;
            end
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
        chk({nm, "_stall_cycles"}, stalls, exp_stall);
        if (memop) chk({nm, "_req_stable"}, {31'd0, unstable}, 32'd0);
        @(posedge clk);
        #1;
        dmem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        ena_gate        = 1'b0;
    endtask

    initial begin : stim
        rq_t r;
        reset                   = 1'b0;
        ena_gate                = 1'b0;
        exe_opcode_in           = OP_ADDU;
        exe_mem_fetch_addr      = 32'd0;
        exe_GPR_rt_in           = 32'd0;
        exe_alu_result_in       = 32'd0;
        exe_pc_in               = 32'd0;
        exe_GPR_we_in           = 1'b0;
        exe_GPR_waddr_in        = 5'd0;
        exe_GPR_wdata_select_in = 2'b00;
        dmem_req_ready          = 1'b0;
        dmem_resp_valid         = 1'b0;
        dmem_resp_rdata         = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("rst_req_we", {31'd0, dmem_req_we}, 32'd0);
        chk("rst_req_addr", dmem_req_addr, 32'd0);
        chk("rst_req_wdata", dmem_req_wdata, 32'd0);
        chk("rst_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_GPR_we}, 32'd0);
        chk("rst_wb_wdata", wb_GPR_wdata, 32'd0);
        chk("rst_wb_pc", wb_pc_out, 32'd0);
        reset = 1'b1;

        // Test 1: abort a load in RESP with reset, then a stale response.
        @(posedge clk);
        #1;
        exe_opcode_in      = DEF_OP_LW;
        exe_mem_fetch_addr = 32'h0000_3000;
        exe_GPR_rt_in      = 32'h0000_0000;
        r.we    = 1'b0;
        r.addr  = 32'h0000_3000;
        r.wdata = 32'h0000_0000;
        rq_q.push_back(r);
        @(negedge clk);
        chk("t1_idle_stall", {31'd0, mem_stall_req}, 32'd1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk("t1_resp_stall", {31'd0, mem_stall_req}, 32'd1);
        chk("t1_resp_valid_low", {31'd0, dmem_req_valid}, 32'd0);
        #2;
        reset         = 1'b0;
        exe_opcode_in = OP_ADDU;
        #1;
        chk("t1_abort_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("t1_abort_req_addr", dmem_req_addr, 32'd0);
        chk("t1_abort_wb_we", {31'd0, wb_GPR_we}, 32'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0000_FEED;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t1_post_stall", {31'd0, mem_stall_req}, 32'd0);
        chk("t1_post_valid", {31'd0, dmem_req_valid}, 32'd0);
        chk("t1_post_wb_wdata", wb_GPR_wdata, 32'd0);
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'd0;
        @(posedge clk);
        #1;

        // load_buf must still be zero after the aborted load
        run_op("t1_loadbuf", OP_ADDU, 32'd0, 32'd0, 32'h0000_0055,
               32'h0000_00F0, 1'b1, 5'd3, 2'b01, 0, 0, 32'd0, 1'b0,
               0, 32'h0000_0000, 32'd0);
        // Test 2: addu
        run_op("t2_addu", OP_ADDU, 32'd0, 32'd0, 32'h0000_0010,
               32'h0000_0100, 1'b1, 5'd5, 2'b00, 0, 0, 32'd0, 1'b0,
               0, 32'h0000_0010, 32'd0);
        // Test 3: unaligned lw, response two cycles after acceptance
        run_op("t3_lw", DEF_OP_LW, 32'h0000_1003, 32'h0000_0000, 32'h0000_1003,
               32'h0000_0104, 1'b1, 5'd8, 2'b01, 0, 2, 32'hDEAD_BEEF, 1'b0,
               4, 32'hDEAD_BEEF, 32'h0000_1000);
        // Test 4: sw with ready held low three cycles
        run_op("t4_sw", DEF_OP_SW, 32'h0000_2000, 32'h1234_5678, 32'h0000_2000,
               32'h0000_0108, 1'b0, 5'd0, 2'b00, 3, 0, 32'd0, 1'b0,
               5, 32'h0000_2000, 32'h0000_2000);
        // Test 5: jal link wraps
        run_op("t5_jal", OP_JAL, 32'd0, 32'd0, 32'h0000_0099,
               32'hFFFF_FFFC, 1'b1, 5'd31, 2'b10, 0, 0, 32'd0, 1'b0,
               0, 32'h0000_0004, 32'd0);
        // Test 6: lw then sw back-to-back, spurious response in IDLE
        run_op("t6_lw", DEF_OP_LW, 32'h0000_0400, 32'h0000_0000, 32'h0000_0400,
               32'h0000_010C, 1'b1, 5'd9, 2'b01, 1, 1, 32'hCAFE_F00D, 1'b0,
               4, 32'hCAFE_F00D, 32'h0000_0400);
        run_op("t6_sw", DEF_OP_SW, 32'h0000_0406, 32'hA5A5_A5A5, 32'h0000_0406,
               32'h0000_0110, 1'b0, 5'd0, 2'b00, 0, 0, 32'd0, 1'b1,
               2, 32'h0000_0406, 32'h0000_0404);
        run_op("t6_loadbuf", OP_ADDU, 32'd0, 32'd0, 32'h0000_0077,
               32'h0000_0114, 1'b1, 5'd10, 2'b01, 0, 0, 32'd0, 1'b0,
               0, 32'hCAFE_F00D, 32'd0);
        run_op("t6_sel11", OP_ADDU, 32'd0, 32'd0, 32'h0000_0077,
               32'h0000_0118, 1'b1, 5'd11, 2'b11, 0, 0, 32'd0, 1'b0,
               0, 32'h0000_0077, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        chk("req_queue_drained", rq_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
